// File: rtl/cam_rgb565_capture_pkg.sv
// Shared constants for the OV7670 RGB565 capture path: frame geometry, RAM widths,
// FSM encodings and the RGB565 -> RGB444 field slicing.
package cam_rgb565_capture_pkg;

  localparam int CAM_SCREEN_X_DEF = 160;
  localparam int CAM_SCREEN_Y_DEF = 120;
  localparam int AW_DEF           = 15;
  localparam int DW_DEF           = 12;

  localparam logic [1:0] ST_WAIT_FRAME = 2'd0;
  localparam logic [1:0] ST_IDLE_LINE  = 2'd1;
  localparam logic [1:0] ST_BYTE1      = 2'd2;
  localparam logic [1:0] ST_BYTE2      = 2'd3;

  // byte1 = {R4..R0,G5..G3}, byte2 = {G2..G0,B4..B0}; keep the top 4 bits of each colour.
  function automatic logic [11:0] rgb565_to_444(input logic [7:0] byte1,
                                                input logic [7:0] byte2);
    return {byte1[7:4], byte1[2:0], byte2[7], byte2[4:1]};
  endfunction

endpackage

// File: rtl/cam_rgb565_capture_conv.sv
// Pure combinational RGB565 -> RGB444 converter, shared with the test pattern generator.
module rgb565_to_rgb444
  import cam_rgb565_capture_pkg::*;
(
  input  logic [15:0] rgb565_i,
  output logic [11:0] rgb444_o
);

  assign rgb444_o = rgb565_to_444(rgb565_i[15:8], rgb565_i[7:0]);

endmodule

// File: rtl/cam_rgb565_capture.sv
// OV7670 RGB565 byte-stream capture: assembles pixels, converts to RGB444 and writes
// them linearly into the frame buffer write port, with frame-complete and overflow flags.
module cam_rgb565_capture
  import cam_rgb565_capture_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int CAM_SCREEN_X = CAM_SCREEN_X_DEF,
  parameter int CAM_SCREEN_Y = CAM_SCREEN_Y_DEF
) (
  input  logic          CAM_pclk,
  input  logic          rst,
  input  logic          CAM_vsync,
  input  logic          CAM_href,
  input  logic [7:0]    CAM_px_data,
  output logic          DP_RAM_regW,
  output logic [AW-1:0] DP_RAM_addr_in,
  output logic [DW-1:0] DP_RAM_data_in,
  output logic          frame_done,
  output logic          px_overflow
);

  localparam int            IMA_SIZ   = CAM_SCREEN_X * CAM_SCREEN_Y;
  localparam logic [AW-1:0] IMA_SIZ_A = AW'(IMA_SIZ);

  logic [1:0]    state_q, state_d;
  logic          vsync_q;
  logic [7:0]    byte1_q, byte1_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          regw_q, regw_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic [11:0]   pix444;
  logic          frame_ok;

  rgb565_to_rgb444 u_conv (
    .rgb565_i ({byte1_q, CAM_px_data}),
    .rgb444_o (pix444)
  );

  // A frame is only reported complete when it filled the buffer exactly.
  assign frame_ok = (cnt_q == IMA_SIZ_A) && !ovf_q;

  always_comb begin
    state_d = state_q;
    byte1_d = byte1_q;
    cnt_d   = cnt_q;
    regw_d  = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    case (state_q)
      ST_WAIT_FRAME: begin
        if (vsync_q && !CAM_vsync) begin
          state_d = ST_IDLE_LINE;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_IDLE_LINE, ST_BYTE1: begin
        if (CAM_vsync) begin
          state_d = ST_WAIT_FRAME;
          done_d  = frame_ok;
        end else if (CAM_href) begin
          byte1_d = CAM_px_data;
          state_d = ST_BYTE2;
        end else begin
          state_d = ST_IDLE_LINE;
        end
      end
      ST_BYTE2: begin
        // A vsync or href drop here discards the half pixel held in byte1_q.
        if (CAM_vsync) begin
          state_d = ST_WAIT_FRAME;
          done_d  = frame_ok;
        end else if (CAM_href) begin
          state_d = ST_BYTE1;
          if (cnt_q < IMA_SIZ_A) begin
            regw_d = 1'b1;
            addr_d = cnt_q;
            data_d = DW'(pix444);
            cnt_d  = cnt_q + AW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE_LINE;
        end
      end
      default: state_d = ST_WAIT_FRAME;
    endcase
  end

  always_ff @(posedge CAM_pclk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_WAIT_FRAME;
      vsync_q <= 1'b0;
      byte1_q <= '0;
      cnt_q   <= '0;
      regw_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= CAM_vsync;
      byte1_q <= byte1_d;
      cnt_q   <= cnt_d;
      regw_q  <= regw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign DP_RAM_regW    = regw_q;
  assign DP_RAM_addr_in = addr_q;
  assign DP_RAM_data_in = data_q;
  assign frame_done     = done_q;
  assign px_overflow    = ovf_q;

endmodule

// File: tb/tb_cam_rgb565_capture.sv
// Directed bench for cam_rgb565_capture at the default 160x120 geometry.
module tb_cam_rgb565_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync;
  logic        href;
  logic [7:0]  pdata;
  logic        regw;
  logic [14:0] addr;
  logic [11:0] data;
  logic        fdone;
  logic        povf;

  int compared   = 0;
  int mismatched = 0;

  int          wr_cnt, done_cnt, seq_err, bad_wr;
  logic [14:0] last_addr, exp_addr;

  cam_rgb565_capture dut (
    .CAM_pclk       (clk),
    .rst            (rst),
    .CAM_vsync      (vsync),
    .CAM_href       (href),
    .CAM_px_data    (pdata),
    .DP_RAM_regW    (regw),
    .DP_RAM_addr_in (addr),
    .DP_RAM_data_in (data),
    .frame_done     (fdone),
    .px_overflow    (povf)
  );

  always #5 clk = ~clk;

  // Write / frame_done activity log, sampled on the inactive edge.
  always @(negedge clk) begin
    if (regw) begin
      wr_cnt++;
      last_addr = addr;
      if (addr != exp_addr) seq_err++;
      exp_addr = addr + 15'd1;
      if (addr >= 15'd19200) bad_wr++;
    end
    if (fdone) done_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    wr_cnt = 0; done_cnt = 0; seq_err = 0; bad_wr = 0;
    last_addr = '0; exp_addr = '0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    href = 1'b1; pdata = b;
    tick();
  endtask

  task automatic idle(input int n);
    href = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic vsync_fall();
    href = 1'b0; vsync = 1'b1;
    tick(); tick();
    vsync = 1'b0;
    tick();
  endtask

  task automatic vsync_rise();
    href = 1'b0; vsync = 1'b1;
    tick();
  endtask

  task automatic send_lines(input int lines, input int gap);
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < 160; x++) begin
        send_byte(8'(x));
        send_byte(8'(y));
      end
      idle(gap);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; vsync = 1'b0; href = 1'b1; pdata = 8'hA5;
    for (int i = 0; i < 3; i++) begin pdata = ~pdata; vsync = ~vsync; tick(); end
    compared++;
    if ({regw, addr, data, fdone, povf} !== 30'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %0h, need 0", {regw, addr, data, fdone, povf});
    end
    vsync = 1'b0;
    clr_mon();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) send_byte(8'(i * 37));
    compared++;
    if (wr_cnt !== 0) begin
      mismatched++;
      $display("FAIL reset_no_write_before_vsync: got %0d writes, need 0", wr_cnt);
    end
    vsync_fall();
    send_byte(8'hF8); send_byte(8'h00);
    compared++;
    if (regw !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_capture_after_vsync: regW=%0b, need 1", regw);
    end
    send_byte(8'h07);
    #2 rst = 1'b0;
    #1;
    compared++;
    if ({regw, addr, data, fdone, povf} !== 30'd0) begin
      mismatched++;
      $display("FAIL reset_midstream: got %0h, need 0", {regw, addr, data, fdone, povf});
    end
    tick(); tick();
    rst = 1'b1;
    clr_mon();
    for (int i = 0; i < 8; i++) send_byte(8'(i + 1));
    compared++;
    if (wr_cnt !== 0) begin
      mismatched++;
      $display("FAIL reset_resume_needs_vsync: got %0d writes, need 0", wr_cnt);
    end
    idle(2);
  endtask

  task automatic test_pixel_write();
    vsync_fall();
    send_byte(8'hF8);
    compared++;
    if (regw !== 1'b0) begin
      mismatched++; $display("FAIL px_no_write_on_byte1: regW=%0b, need 0", regw);
    end
    send_byte(8'h00);
    compared++;
    if ({regw, addr, data} !== {1'b1, 15'd0, 12'hF00}) begin
      mismatched++;
      $display("FAIL px_red: regW=%0b addr=%0d data=%03h, need 1/0/F00", regw, addr, data);
    end
    send_byte(8'h07);
    compared++;
    if (regw !== 1'b0) begin
      mismatched++; $display("FAIL px_pulse_width: regW=%0b, need 0", regw);
    end
    send_byte(8'hE0);
    compared++;
    if ({regw, addr, data} !== {1'b1, 15'd1, 12'h0F0}) begin
      mismatched++;
      $display("FAIL px_green: regW=%0b addr=%0d data=%03h, need 1/1/0F0", regw, addr, data);
    end
  endtask

  task automatic test_color_patterns();
    vsync_fall();
    send_byte(8'h00); send_byte(8'h1F);
    compared++;
    if ({regw, addr, data} !== {1'b1, 15'd0, 12'h00F}) begin
      mismatched++;
      $display("FAIL col_blue: regW=%0b addr=%0d data=%03h, need 1/0/00F", regw, addr, data);
    end
    send_byte(8'hFF);
    compared++;
    if (regw !== 1'b0) begin
      mismatched++; $display("FAIL col_pulse_width: regW=%0b, need 0", regw);
    end
    send_byte(8'hFF);
    compared++;
    if ({regw, addr, data} !== {1'b1, 15'd1, 12'hFFF}) begin
      mismatched++;
      $display("FAIL col_white: regW=%0b addr=%0d data=%03h, need 1/1/FFF", regw, addr, data);
    end
    send_byte(8'h12); send_byte(8'h34);
    compared++;
    if ({regw, addr, data} !== {1'b1, 15'd2, 12'h14A}) begin
      mismatched++;
      $display("FAIL col_mixed: regW=%0b addr=%0d data=%03h, need 1/2/14A", regw, addr, data);
    end
    idle(1);
    compared++;
    if ({regw, addr, data} !== {1'b0, 15'd2, 12'h14A}) begin
      mismatched++;
      $display("FAIL col_hold: regW=%0b addr=%0d data=%03h, need 0/2/14A", regw, addr, data);
    end
    vsync_rise();
    compared++;
    if ({fdone, povf} !== 2'b00) begin
      mismatched++;
      $display("FAIL col_short_frame: done=%0b ovf=%0b, need 0/0", fdone, povf);
    end
  endtask

  task automatic test_href_drop();
    vsync_fall();
    clr_mon();
    for (int p = 0; p < 5; p++) begin send_byte(8'h10 + 8'(p)); send_byte(8'h80); end
    send_byte(8'hAA);
    idle(4);
    compared++;
    if (wr_cnt !== 5 || regw !== 1'b0) begin
      mismatched++;
      $display("FAIL drop_half_pixel: writes=%0d regW=%0b, need 5/0", wr_cnt, regw);
    end
    send_byte(8'h12); send_byte(8'h34);
    compared++;
    if ({regw, addr, data} !== {1'b1, 15'd5, 12'h14A}) begin
      mismatched++;
      $display("FAIL drop_next_line: regW=%0b addr=%0d data=%03h, need 1/5/14A", regw, addr, data);
    end
  endtask

  task automatic test_full_frame();
    vsync_fall();
    clr_mon();
    send_lines(120, 4);
    vsync_rise();
    compared++;
    if (fdone !== 1'b1) begin
      mismatched++; $display("FAIL full_done_pulse: frame_done=%0b, need 1", fdone);
    end
    tick(); tick();
    compared++;
    if (wr_cnt !== 19200) begin
      mismatched++; $display("FAIL full_write_count: got %0d, need 19200", wr_cnt);
    end
    compared++;
    if (last_addr !== 15'd19199 || seq_err !== 0) begin
      mismatched++;
      $display("FAIL full_addresses: last=%0d seq_err=%0d, need 19199/0", last_addr, seq_err);
    end
    compared++;
    if (done_cnt !== 1 || povf !== 1'b0) begin
      mismatched++;
      $display("FAIL full_done_once: done_cycles=%0d ovf=%0b, need 1/0", done_cnt, povf);
    end
  endtask

  task automatic test_overflow();
    vsync_fall();
    clr_mon();
    send_lines(120, 1);
    send_byte(8'hF8); send_byte(8'h00);
    compared++;
    if ({regw, povf} !== 2'b01) begin
      mismatched++;
      $display("FAIL ovf_extra_pixel: regW=%0b ovf=%0b, need 0/1", regw, povf);
    end
    idle(2);
    vsync_rise();
    tick();
    compared++;
    if (wr_cnt !== 19200 || bad_wr !== 0) begin
      mismatched++;
      $display("FAIL ovf_writes: writes=%0d out_of_range=%0d, need 19200/0", wr_cnt, bad_wr);
    end
    compared++;
    if (done_cnt !== 0 || povf !== 1'b1) begin
      mismatched++;
      $display("FAIL ovf_no_done_sticky: done_cycles=%0d ovf=%0b, need 0/1", done_cnt, povf);
    end
    vsync_fall();
    compared++;
    if (povf !== 1'b0) begin
      mismatched++; $display("FAIL ovf_cleared: ovf=%0b, need 0", povf);
    end
    send_byte(8'h07); send_byte(8'hE0);
    compared++;
    if ({regw, addr, data} !== {1'b1, 15'd0, 12'h0F0}) begin
      mismatched++;
      $display("FAIL ovf_restart: regW=%0b addr=%0d data=%03h, need 1/0/0F0", regw, addr, data);
    end
  endtask

  initial begin
    rst = 1'b0; vsync = 1'b0; href = 1'b0; pdata = 8'h00;
    clr_mon();
    test_reset();
    test_pixel_write();
    test_color_patterns();
    test_href_drop();
    test_full_frame();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
